// File: rtl/csel_addsub_pipe_if.sv
// csel_addsub_pipe_if -- operand/result handshake bundle for csel_addsub_pipe.
//   master : drives in_valid, a, b, sub, out_ready; sees in_ready, out_valid, s, co, ovf
//   slave  : the adder side of the same signals
// Optional macro CSEL_ADDSUB_SAT_EN adds the 1-bit sat result flag.
interface csel_addsub_pipe_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ovf;
`ifdef CSEL_ADDSUB_SAT_EN
  logic             sat;
`endif

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, s, co, ovf
`ifdef CSEL_ADDSUB_SAT_EN
    , input sat
`endif
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, s, co, ovf
`ifdef CSEL_ADDSUB_SAT_EN
    , output sat
`endif
  );
endinterface

// File: rtl/csel_addsub_pipe.sv
// csel_addsub_pipe -- pipelined carry-select adder/subtractor.
//   s/co = a + (b ^ {WIDTH{sub}}) + sub, ovf = signed overflow.
//   One pipeline stage per BLK-bit block, latency NBLK = WIDTH/BLK, 1 op/cycle.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - csel_addsub_pipe_if.slave (in_valid/in_ready/a/b/sub,
//          out_valid/out_ready/s/co/ovf[/sat])
// Optional macro CSEL_ADDSUB_SAT_EN: unsigned saturation at the last stage
//   (add overflow -> all ones, sub borrow -> 0) with a sat flag; co/ovf stay raw.
module csel_addsub_pipe #(
  parameter int WIDTH = 16,
  parameter int BLK   = 4
) (
  input  logic              clk,
  input  logic              rst,
  csel_addsub_pipe_if.slave bus
);
  localparam int NBLK   = WIDTH / BLK;
  localparam int STAGES = NBLK - 1;

  // {carry_out, sum} of one block
  function automatic logic [BLK:0] blk_add(input logic [BLK-1:0] x,
                                           input logic [BLK-1:0] y,
                                           input logic           ci);
    return {1'b0, x} + {1'b0, y} + {{BLK{1'b0}}, ci};
  endfunction

  logic             en;
  logic [STAGES:0]  vld_pipe;
  logic [WIDTH-1:0] s_o;
  logic             co_o;
  logic             ovf_o;
`ifdef CSEL_ADDSUB_SAT_EN
  logic             sat_o;
  assign bus.sat = sat_o;
`endif

  // Whole pipe advances together; a stalled output freezes every stage.
  assign en            = !vld_pipe[STAGES] || bus.out_ready;
  assign bus.in_ready  = en;
  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.s         = s_o;
  assign bus.co        = co_o;
  assign bus.ovf       = ovf_o;

  always_ff @(posedge clk) begin
    if (rst)     vld_pipe <= '0;
    else if (en) vld_pipe <= (vld_pipe << 1) | (STAGES+1)'(bus.in_valid);
  end

  for (genvar k = 0; k < NBLK; k++) begin : g_stg
    localparam int LO = k * BLK;
    localparam int HI = (k + 1) * BLK;

    // operand bits still to be summed (b already conditionally inverted)
    logic [WIDTH-1:LO] a_src;
    logic [WIDTH-1:LO] b_src;
    logic [HI-1:0]     sum;   // result bits resolved up to this block
    logic [BLK:0]      r;     // this block: {carry_out, sum}
`ifdef CSEL_ADDSUB_SAT_EN
    logic              sub_src;
`endif

    if (k == 0) begin : g_in
      assign a_src = bus.a;
      assign b_src = bus.b ^ {WIDTH{bus.sub}};
      assign r     = blk_add(a_src[HI-1:LO], b_src[HI-1:LO], bus.sub);
      assign sum   = r[BLK-1:0];
`ifdef CSEL_ADDSUB_SAT_EN
      assign sub_src = bus.sub;
`endif
    end else begin : g_sel
      // both carry-in candidates in parallel; the registered carry only muxes
      logic [BLK:0] r0;
      logic [BLK:0] r1;
      assign a_src = g_stg[k-1].g_reg.a_q;
      assign b_src = g_stg[k-1].g_reg.b_q;
      assign r0    = blk_add(a_src[HI-1:LO], b_src[HI-1:LO], 1'b0);
      assign r1    = blk_add(a_src[HI-1:LO], b_src[HI-1:LO], 1'b1);
      assign r     = g_stg[k-1].g_reg.c_q ? r1 : r0;
      assign sum   = {r[BLK-1:0], g_stg[k-1].g_reg.s_q};
`ifdef CSEL_ADDSUB_SAT_EN
      assign sub_src = g_stg[k-1].g_reg.sub_q;
`endif
    end

    if (k < STAGES) begin : g_reg
      logic [HI-1:0]     s_q;
      logic              c_q;
      logic [WIDTH-1:HI] a_q;
      logic [WIDTH-1:HI] b_q;
`ifdef CSEL_ADDSUB_SAT_EN
      logic              sub_q;
      always_ff @(posedge clk) if (en) sub_q <= sub_src;
`endif
      always_ff @(posedge clk) begin
        if (en) begin
          s_q <= sum;
          c_q <= r[BLK];
          a_q <= a_src[WIDTH-1:HI];
          b_q <= b_src[WIDTH-1:HI];
        end
      end
    end else begin : g_out
      // carry into the MSB recovered from the MSB sum bit
      logic cm;
      assign cm = a_src[WIDTH-1] ^ b_src[WIDTH-1] ^ sum[WIDTH-1];
`ifdef CSEL_ADDSUB_SAT_EN
      // add clamps on carry, sub clamps on borrow (co=0)
      logic sat_hit;
      assign sat_hit = sub_src ? !r[BLK] : r[BLK];
`endif
      always_ff @(posedge clk) begin
        if (rst) begin
          s_o   <= '0;
          co_o  <= 1'b0;
          ovf_o <= 1'b0;
`ifdef CSEL_ADDSUB_SAT_EN
          sat_o <= 1'b0;
`endif
        end else if (en) begin
`ifdef CSEL_ADDSUB_SAT_EN
          s_o   <= sat_hit ? {WIDTH{!sub_src}} : sum;
          sat_o <= sat_hit;
`else
          s_o   <= sum;
`endif
          co_o  <= r[BLK];
          ovf_o <= r[BLK] ^ cm;
        end
      end
    end
  end
endmodule

// File: tb/tb_csel_addsub_pipe.sv
// tb_csel_addsub_pipe -- randomized + directed self-checking bench for
// csel_addsub_pipe (WIDTH=16, BLK=4). Reference is plain integer arithmetic;
// expected results are queued on acceptance and popped on each output handshake.
module tb_csel_addsub_pipe;
  localparam int W    = 16;
  localparam int B    = 4;
  localparam int NBLK = W / B;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  csel_addsub_pipe_if #(.WIDTH(W)) bif();
  csel_addsub_pipe #(.WIDTH(W), .BLK(B)) dut (.clk(clk), .rst(rst), .bus(bif));

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ovf;
    logic         sat;
    int           cyc;
    bit           lat;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] s;
    logic         co;
    logic         ovf;
  } vec_t;

  exp_t         q[$];
  exp_t         cur_exp;
  vec_t         vt[10];
  int           n_chk = 0;
  int           n_err = 0;
  int           cyc   = 0;
  int           rdy_mode = 0;
  int           stall_lo = 0;
  int           stall_hi = 0;
  bit           acc;
  bit           hold_v = 0;
  logic [W-1:0] hold_s;
  bit           ov_hist[0:2047];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t sat_fix(input exp_t e, input logic sub);
    exp_t r = e;
    r.sat = 1'b0;
`ifdef CSEL_ADDSUB_SAT_EN
    if (!sub && r.co) begin r.s = '1; r.sat = 1'b1; end
    if (sub && !r.co) begin r.s = '0; r.sat = 1'b1; end
`endif
    return r;
  endfunction

  function automatic exp_t mk(input logic [W-1:0] s, input logic co, input logic ovf,
                              input logic sub);
    exp_t e;
    e.s = s; e.co = co; e.ovf = ovf; e.sat = 1'b0; e.cyc = 0; e.lat = 1'b1;
    return sat_fix(e, sub);
  endfunction

  // unsigned/signed integer view of the operation
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sub);
    exp_t   e;
    longint ua, ub, sa, sb, r, sr;
    ua = longint'(a);           ub = longint'(b);
    sa = longint'($signed(a));  sb = longint'($signed(b));
    r  = sub ? ua - ub : ua + ub;
    sr = sub ? sa - sb : sa + sb;
    e.s   = W'(r);
    e.co  = sub ? (ua >= ub) : (r >= (longint'(1) << W));
    e.ovf = (sr > (longint'(1) << (W-1)) - 1) || (sr < -(longint'(1) << (W-1)));
    e.sat = 1'b0; e.cyc = 0; e.lat = 1'b0;
    return sat_fix(e, sub);
  endfunction

  // one clock: drive out_ready, sample at negedge, then step past posedge
  task automatic tick();
    exp_t e;
    case (rdy_mode)
      0:       bif.out_ready = 1'b1;
      1:       bif.out_ready = !(cyc >= stall_lo && cyc < stall_hi);
      default: bif.out_ready = ($urandom_range(0, 3) != 0);
    endcase
    @(negedge clk);
    chk("in_ready", bif.in_ready, !bif.out_valid || bif.out_ready);
    if (hold_v && !rst) begin
      chk("hold_valid", bif.out_valid, 1);
      chk("hold_s", bif.s, hold_s);
    end
    hold_v = 0;
    if (cyc < 2048) ov_hist[cyc] = bif.out_valid;
    acc = bif.in_valid && bif.in_ready && !rst;
    if (!rst) begin
      if (bif.out_valid && bif.out_ready) begin
        if (q.size() == 0) chk("spurious_out", 1, 0);
        else begin
          e = q.pop_front();
          chk("s", bif.s, e.s);
          chk("co", bif.co, e.co);
          chk("ovf", bif.ovf, e.ovf);
`ifdef CSEL_ADDSUB_SAT_EN
          chk("sat", bif.sat, e.sat);
`endif
          if (e.lat) chk("latency", cyc - e.cyc, NBLK);
        end
      end else if (bif.out_valid) begin
        hold_v = 1;
        hold_s = bif.s;
      end
      if (acc) begin
        e = cur_exp;
        e.cyc = cyc;
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       input exp_t e);
    int g = 0;
    bif.in_valid = 1'b1; bif.a = a; bif.b = b; bif.sub = sub;
    cur_exp = e;
    do begin tick(); g++; end while (!acc && g < 50);
    if (!acc) chk("accept_timeout", 0, 1);
  endtask

  task automatic issue_rnd(input bit lat);
    logic [W-1:0] a, b;
    logic         sub;
    exp_t         e;
    a = W'($urandom()); b = W'($urandom()); sub = 1'($urandom_range(0, 1));
    e = model(a, b, sub);
    e.lat = lat;
    issue(a, b, sub, e);
  endtask

  task automatic drain();
    int g = 0;
    bif.in_valid = 1'b0;
    while ((q.size() != 0 || bif.out_valid) && g < 100) begin tick(); g++; end
    chk("drain_left", q.size(), 0);
    tick();
  endtask

  initial begin
    int c0;
    vt = '{
      '{16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0},
      '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0},
      '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1},
      '{16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0},
      '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0},
      '{16'h5A5A, 16'h0000, 1'b1, 16'h5A5A, 1'b1, 1'b0},
      '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1},
      '{16'hFFFF, 16'h0002, 1'b0, 16'h0001, 1'b1, 1'b0},
      '{16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0},
      '{16'h0010, 16'h0001, 1'b0, 16'h0011, 1'b0, 1'b0}
    };
    rst = 1'b1;
    bif.in_valid = 1'b0; bif.a = '0; bif.b = '0; bif.sub = 1'b0; bif.out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_out_valid", bif.out_valid, 0);
    chk("rst_s", bif.s, 0);
    chk("rst_co", bif.co, 0);
    chk("rst_ovf", bif.ovf, 0);
    chk("rst_in_ready", bif.in_ready, 1);
`ifdef CSEL_ADDSUB_SAT_EN
    chk("rst_sat", bif.sat, 0);
`endif

    // directed edge cases, back to back, exact latency
    foreach (vt[i]) issue(vt[i].a, vt[i].b, vt[i].sub, mk(vt[i].s, vt[i].co, vt[i].ovf, vt[i].sub));
    drain();

    // 8 back-to-back ops with a 3-cycle output stall mid-stream
    rdy_mode = 1; stall_lo = cyc + 5; stall_hi = cyc + 8;
    for (int i = 0; i < 8; i++) issue_rnd(1'b0);
    drain();
    rdy_mode = 0;

    // bubbles: in_valid 1,0,1,0 -> out_valid 1,0,1,0 from cycle NBLK
    issue_rnd(1'b1);
    c0 = cyc - 1;
    bif.in_valid = 1'b0; tick();
    issue_rnd(1'b1);
    bif.in_valid = 1'b0; tick();
    drain();
    for (int i = 0; i < 4; i++) chk("bubble_ov", ov_hist[c0 + NBLK + i], (i % 2 == 0));

    // reset with 3 ops in flight
    for (int i = 0; i < 3; i++) issue_rnd(1'b1);
    rst = 1'b1; bif.in_valid = 1'b0; q.delete();
    tick();
    rst = 1'b0;
    chk("midrst_out_valid", bif.out_valid, 0);
    chk("midrst_s", bif.s, 0);
    chk("midrst_co", bif.co, 0);
    chk("midrst_ovf", bif.ovf, 0);
    chk("midrst_in_ready", bif.in_ready, 1);
    issue_rnd(1'b1);
    drain();

    // random traffic with random gaps and random backpressure
    rdy_mode = 2;
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 3) == 0) begin bif.in_valid = 1'b0; tick(); end
      issue_rnd(1'b0);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end
endmodule

// File: doc/csel_addsub_pipe.md
Name: csel_addsub_pipe

Overview:
- Parametrised, pipelined carry-select adder/subtractor. Successor to the fixed 16-bit, 4-bit-block combinational subtractor.
- Adds per-operation add/sub mode, configurable width and block size, one pipeline stage per block, and a valid/ready handshake.
- Sits in the datapath of the improved logarithmic multiplier, for mantissa/exponent correction adds and subtracts at full clock rate.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of BLK.
- BLK, 4, carry-select block width in bits. NBLK = WIDTH/BLK is both the stage count and the latency.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operands valid
- in_ready  output  1  operands accepted when in_valid && in_ready
- a  input  WIDTH  minuend / augend
- b  input  WIDTH  subtrahend / addend
- sub  input  1  0 = a+b, 1 = a-b
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- s  output  WIDTH  result, modulo 2^WIDTH
- co  output  1  carry out; for sub, 1 = no borrow (a >= b unsigned)
- ovf  output  1  signed two's-complement overflow

Behaviour:
- Interface: one clock, clk; synchronous active-high reset, rst.
- Arithmetic: s/co = a + (b XOR {WIDTH{sub}}) + sub.
  - Carry-in to block 0 is sub. No separate +1 on b, so b=0 in sub mode gives co=1.
  - ovf = carry into MSB XOR carry out of MSB.
- Pipeline structure:
  - Stage 0 registers block 0's sum and carry, plus the remaining operand bits (b already conditionally inverted) and the sub flag.
  - Stage k (1..NBLK-1) computes block k twice, with ci=0 and ci=1, and selects using the registered carry from stage k-1.
  - Each stage forwards lower result blocks and upper operand bits.
  - No ripple across a stage boundary.
- Latency and throughput:
  - Latency is exactly NBLK cycles from acceptance to out_valid with no stall.
  - Throughput is one operation per cycle.
- Flow control:
  - Global advance enable en = !out_valid || out_ready.
  - in_ready = en, combinational.
  - When en=0, every stage register, including its valid bit, holds.
  - Bubbles (in_valid=0 while en=1) propagate as valid=0 stages. Results are never dropped or duplicated, and order is preserved.
- Outputs:
  - s, co, ovf are registered and hold stable while out_valid && !out_ready.
  - Values when out_valid=0 are don't-care, but reset drives them to 0.
- Reset:
  - All stage valid bits clear; out_valid=0, s=0, co=0, ovf=0.
  - Reset mid-operation discards in-flight operations.
  - in_ready=1 the cycle after reset deasserts.
- Simultaneous events:
  - Accept on the same cycle as a result handshake is legal: pipeline shifts by one.
  - rst dominates all handshakes.
- Degenerate case: NBLK=1 gives a single-stage registered adder with latency 1.

Optional Feature:
- Macro: CSEL_ADDSUB_SAT_EN.
- When defined:
  - Unsigned saturation is applied at the last stage.
  - Add with co=1 → s = all ones.
  - Sub with co=0 (borrow) → s = 0.
  - Extra output port sat (1 bit) flags that clamping occurred; reset 0.
  - co and ovf still report raw arithmetic.
- When undefined: s wraps modulo 2^WIDTH and port sat does not exist.

Test Plan (WIDTH=16, BLK=4, latency 4 unless noted):
- Add and cross-block carry:
  - sub=0, a=0x1234, b=0x0FCD → s=0x2201, co=0, ovf=0 on cycle 4.
  - a=0xFFFF, b=0x0001 → s=0x0000, co=1, ovf=0; exercises carry through all blocks.
  - a=0x7FFF, b=0x0001 → s=0x8000, co=0, ovf=1.
- Subtract edge cases:
  - sub=1, a=0x1234, b=0x1234 → s=0, co=1.
  - a=0x0000, b=0x0001 → s=0xFFFF, co=0.
  - a=0x5A5A, b=0x0000 → s=0x5A5A, co=1; b=0 must not borrow.
  - a=0x8000, b=0x0001 → s=0x7FFF, ovf=1.
- Streaming with backpressure:
  - 8 back-to-back random mixed add/sub ops with out_ready=0 for 3 cycles mid-stream.
  - in_ready follows en; all 8 results emerge in order, matching the reference model, with s held stable while stalled.
- Bubbles: in_valid toggling 1,0,1,0 with out_ready=1 → out_valid pattern 1,0,1,0 starting at cycle 4.
- Reset mid-flight:
  - Assert rst for 1 cycle with 3 ops in flight → out_valid=0, s=0, co=0, ovf=0 next cycle.
  - No stale result ever appears; a new op issued immediately after completes correctly.
- CSEL_ADDSUB_SAT_EN defined:
  - 0xFFFF+0x0002 → s=0xFFFF, sat=1, co=1.
  - 0x0003−0x0005 → s=0x0000, sat=1.
  - 0x0010+0x0001 → s=0x0011, sat=0.
  - Also rerun with WIDTH=32, BLK=8 (latency 4), and with WIDTH=8, BLK=8 (latency 1).
